// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : fetch FSM states (REQ / WAIT / HOLD)
//   FETCH_RESET_ADDR : default PC loaded on reset
//   word_align()     : clears the two low address bits
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH_ST_REQ  = 2'd0,
    FETCH_ST_WAIT = 2'd1,
    FETCH_ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [63:0] FETCH_RESET_ADDR = 64'h0000_0000_8000_0000;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_hold_buffer.sv
// One-entry {pc, inst} buffer that parks a fetched instruction while decode
// is stalled.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture load_pc / load_inst, mark full
//   clear               : drop the entry (wins over load)
//   load_pc, load_inst  : data to capture
//   full, pc, inst      : buffer contents
module fetch_hold_buffer
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        full,
  output logic [63:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      pc   <= '0;
      inst <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      pc   <= load_pc;
      inst <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps the fetch PC, issues one instruction
// request at a time over req/gnt/rvalid, and presents {valid, pc, next_pc,
// inst} combinationally to decode. A redirect cancels any in-flight or
// buffered fetch.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   stall_i                       : decode not accepting this cycle
//   redirect_i, redirect_pc_i     : control-flow redirect and target
//   imem_req_o/gnt_i/addr_o       : request channel
//   imem_rvalid_i/rdata_i         : response channel
//   valid_o, pc_o, next_pc_o, inst_o : instruction presented to decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_ADDR = FETCH_RESET_ADDR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  input  logic        imem_gnt_i,
  output logic [63:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o,
  output logic [31:0] inst_o
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;

  logic         hb_load, hb_clear, hb_full;
  logic [63:0]  hb_pc;
  logic [31:0]  hb_inst;

  logic         req, valid, take_next;
  logic [63:0]  out_pc;
  logic [31:0]  out_inst;

  fetch_hold_buffer u_hold (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (hb_load),
    .clear     (hb_clear),
    .load_pc   (req_pc_q),
    .load_inst (imem_rdata_i),
    .full      (hb_full),
    .pc        (hb_pc),
    .inst      (hb_inst)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FETCH_ST_REQ;
      pc_q     <= RESET_ADDR;
      req_pc_q <= RESET_ADDR;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    hb_load   = 1'b0;
    hb_clear  = 1'b0;
    req       = 1'b0;
    valid     = 1'b0;
    take_next = 1'b0;
    out_pc    = req_pc_q;
    out_inst  = '0;

    unique case (state_q)
      FETCH_ST_REQ: begin
        // The old address may still be granted in a redirect cycle; that
        // response is then marked for discard.
        req = 1'b1;
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          drop_d   = redirect_i;
          state_d  = FETCH_ST_WAIT;
        end
        if (redirect_i) pc_d = word_align(redirect_pc_i);
      end

      FETCH_ST_WAIT: begin
        if (redirect_i) begin
          pc_d = word_align(redirect_pc_i);
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = FETCH_ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH_ST_REQ;
          end else begin
            valid    = 1'b1;
            out_inst = imem_rdata_i;
            if (stall_i) begin
              hb_load = 1'b1;
              state_d = FETCH_ST_HOLD;
            end else begin
              take_next = 1'b1;
            end
          end
        end
      end

      FETCH_ST_HOLD: begin
        out_pc   = hb_pc;
        out_inst = hb_inst;
        if (redirect_i) begin
          hb_clear = 1'b1;
          pc_d     = word_align(redirect_pc_i);
          state_d  = FETCH_ST_REQ;
        end else begin
          valid = hb_full;
          if (!stall_i) begin
            hb_clear  = 1'b1;
            take_next = 1'b1;
          end
        end
      end

      default: state_d = FETCH_ST_REQ;
    endcase

    // Consuming the presented instruction issues the next request in the
    // same cycle, giving back-to-back fetch with single-cycle memory.
    if (take_next) begin
      req = 1'b1;
      if (imem_gnt_i) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 64'd4;
        state_d  = FETCH_ST_WAIT;
      end else begin
        state_d = FETCH_ST_REQ;
      end
    end
  end

  assign imem_req_o  = req & rst_ni;
  assign imem_addr_o = pc_q;
  assign valid_o     = valid;
  assign pc_o        = out_pc;
  assign next_pc_o   = out_pc + 64'd4;
  assign inst_o      = out_inst;

endmodule
